// File: rtl/imm_ext_pipe_pkg.sv
// Shared definitions for the immediate-extension pipe: mode encodings and the
// width-generic extension function used by the top-level mux.
package imm_ext_pkg;

  // Widest OUT_W the extension function supports.
  localparam int EXT_MAX_W = 64;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_UPPER = 2'd2,
    EXT_RSVD  = 2'd3
  } ext_mode_e;

  typedef logic [EXT_MAX_W-1:0] ext_word_t;

  // Extends the low in_w bits of imm according to mode. The caller truncates the
  // result to out_w bits. Widths are elaboration constants at every call site,
  // so the masks and shifts fold to wiring.
  function automatic ext_word_t ext_by_mode(input ext_word_t imm,
                                            input int        in_w,
                                            input int        out_w,
                                            input ext_mode_e mode);
    ext_word_t lo_mask;
    ext_word_t imm_lo;
    ext_word_t res;
    logic      sign;
    lo_mask = ~({EXT_MAX_W{1'b1}} << in_w);
    imm_lo  = imm & lo_mask;
    sign    = |(imm_lo & (ext_word_t'(1) << (in_w - 1)));
    case (mode)
      EXT_SIGN:  res = sign ? (imm_lo | ~lo_mask) : imm_lo;
      EXT_ZERO:  res = imm_lo;
      EXT_UPPER: res = imm_lo << (out_w - in_w);
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Producer/consumer handshake bundle of imm_ext_pipe. The design side uses the
// slave modport; whoever drives immediates and drains results uses master.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;
  logic [1:0]       out_count;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_count
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err, out_count
  );
endinterface

// File: rtl/imm_ext_pipe_skid_buf2.sv
// Two-entry circular valid/ready buffer. Readiness and validity depend only on
// the registered occupancy, so there is no combinational out_ready -> in_ready
// path. Entry storage is not reset; the output is masked while empty.
module ext_skid_buf2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   out_count_o
);

  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic [W-1:0] mem_q [2];
  logic         push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // Next pointers and occupancy; push+pop together leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the buffer and drops out_valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written only on push and otherwise holding its value.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign out_count_o = count_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit: widens IN_W-bit immediates to OUT_W bits
// (sign, zero, or upper placement) and queues {err, data} in a 2-entry buffer.
// Build option: define IMM_EXT_UPPER_EN to enable mode 2 (upper placement);
// without it, mode 2 is treated like the reserved mode (data 0, err 1).
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input logic            clk,
  input logic            rst_n,
  imm_ext_pipe_if.slave  bus
);

  ext_word_t      imm_w;
  ext_word_t      ext_full;
  logic           ext_err;
  ext_mode_e      mode;
  logic [OUT_W:0] buf_in;
  logic [OUT_W:0] buf_out;

  assign imm_w = ext_word_t'(bus.in_imm);
  assign mode  = ext_mode_e'(bus.in_mode);

  // Extension mux; any mode not built in yields zero data with err set.
  always_comb begin
    ext_full = '0;
    ext_err  = 1'b0;
    case (mode)
      EXT_SIGN:  ext_full = ext_by_mode(imm_w, IN_W, OUT_W, EXT_SIGN);
      EXT_ZERO:  ext_full = ext_by_mode(imm_w, IN_W, OUT_W, EXT_ZERO);
`ifdef IMM_EXT_UPPER_EN
      EXT_UPPER: ext_full = ext_by_mode(imm_w, IN_W, OUT_W, EXT_UPPER);
`endif
      default: begin
        ext_full = '0;
        ext_err  = 1'b1;
      end
    endcase
  end

  // Bits above OUT_W are never stored.
  if (OUT_W < EXT_MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^ext_full[EXT_MAX_W-1:OUT_W];
  end

  assign buf_in = {ext_err, ext_full[OUT_W-1:0]};

  ext_skid_buf2 #(.W(OUT_W + 1)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (buf_in),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (buf_out),
    .out_count_o (bus.out_count)
  );

  assign bus.out_data = buf_out[OUT_W-1:0];
  assign bus.out_err  = buf_out[OUT_W];

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [32:0] mq [$];

  imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  // Reference extension from the arithmetic meaning of each mode.
  function automatic logic [32:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int v;
    v = int'(imm);
    if (mode == 2'd0) begin
      if (v >= 32768) v = v - 65536;
      return {1'b0, 32'(v)};
    end
    if (mode == 2'd1) return {1'b0, 32'(v)};
`ifdef IMM_EXT_UPPER_EN
    if (mode == 2'd2) return {1'b0, 32'(v * 65536)};
`endif
    return {1'b1, 32'h0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int          n;
    logic [32:0] head;
    n    = mq.size();
    head = (n != 0) ? mq[0] : 33'h0;
    chk("in_ready",  32'(bus.in_ready),  32'(n != 2));
    chk("out_valid", 32'(bus.out_valid), 32'(n != 0));
    chk("out_count", 32'(bus.out_count), 32'(n));
    chk("out_data",  bus.out_data,       head[31:0]);
    chk("out_err",   32'(bus.out_err),   32'(head[32]));
  endtask

  task automatic expect_head(input string name, input logic [31:0] d, input logic e);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'h1);
    chk({name, "_data"},  bus.out_data,       d);
    chk({name, "_err"},   32'(bus.out_err),   32'(e));
  endtask

  // One clock: drive, check against model, advance model at the edge.
  task automatic cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic ordy);
    logic push, pop;
    bus.in_valid  = v;
    bus.in_imm    = imm;
    bus.in_mode   = mode;
    bus.out_ready = ordy;
    #1;
    check_outputs();
    push = v && (mq.size() != 2);
    pop  = ordy && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(ref_ext(imm, mode));
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{16'h8FFF, 2'd0, 32'hFFFF8FFF, 1'b0};
    vecs[1] = '{16'h0FFF, 2'd0, 32'h00000FFF, 1'b0};
    vecs[2] = '{16'h8FFF, 2'd1, 32'h00008FFF, 1'b0};
`ifdef IMM_EXT_UPPER_EN
    vecs[3] = '{16'h1234, 2'd2, 32'h12340000, 1'b0};
`else
    vecs[3] = '{16'h1234, 2'd2, 32'h00000000, 1'b1};
`endif
    vecs[4] = '{16'hABCD, 2'd3, 32'h00000000, 1'b1};
    vecs[5] = '{16'h7FFF, 2'd0, 32'h00007FFF, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = 2'd0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  bus.out_data,       32'h0);
    chk("rst_out_err",   32'(bus.out_err),   32'h0);
    chk("rst_out_count", 32'(bus.out_count), 32'h0);
    rst_n = 1'b1;
    cycle(1'b0, 16'h0, 2'd0, 1'b0);
    cycle(1'b0, 16'h0, 2'd0, 1'b1);

    // Mode table: each result visible one cycle after its push.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vecs[i].imm, vecs[i].mode, 1'b1);
      expect_head($sformatf("mode%0d", i), vecs[i].exp_data, vecs[i].exp_err);
    end
    cycle(1'b0, 16'h0, 2'd0, 1'b1);

    // Backpressure: fill, refuse third offer, pop-only at full, then push+pop.
    cycle(1'b1, 16'h0001, 2'd0, 1'b0);
    cycle(1'b1, 16'h0002, 2'd0, 1'b0);
    chk("bp_count2", 32'(bus.out_count), 32'h2);
    chk("bp_notready", 32'(bus.in_ready), 32'h0);
    cycle(1'b1, 16'h0003, 2'd0, 1'b0);
    expect_head("bp_hold", 32'h00000001, 1'b0);
    cycle(1'b1, 16'h0003, 2'd0, 1'b1);
    chk("bp_poponly_count", 32'(bus.out_count), 32'h1);
    expect_head("bp_second", 32'h00000002, 1'b0);
    cycle(1'b1, 16'h0003, 2'd0, 1'b1);
    expect_head("bp_third", 32'h00000003, 1'b0);
    cycle(1'b0, 16'h0, 2'd0, 1'b1);

    // Streaming at occupancy 1 across several pointer wraps.
    cycle(1'b1, 16'h0100, 2'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("stream_count", 32'(bus.out_count), 32'h1);
      expect_head("stream", 32'h00000100 + 32'(i), 1'b0);
      cycle(1'b1, 16'h0101 + 16'(i), 2'd1, 1'b1);
    end
    expect_head("stream_last", 32'h00000108, 1'b0);
    cycle(1'b0, 16'h0, 2'd0, 1'b1);

    // Asynchronous reset while full.
    cycle(1'b1, 16'h0011, 2'd0, 1'b0);
    cycle(1'b1, 16'h0022, 2'd0, 1'b0);
    chk("pre_rst_count", 32'(bus.out_count), 32'h2);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("async_rst_count", 32'(bus.out_count), 32'h0);
    chk("async_rst_ready", 32'(bus.in_ready),  32'h1);
    chk("async_rst_data",  bus.out_data,       32'h0);
    mq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b1, 16'hFFFF, 2'd0, 1'b1);
    expect_head("post_rst", 32'hFFFFFFFF, 1'b0);
    cycle(1'b0, 16'h0, 2'd0, 1'b1);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0));
    end
    cycle(1'b0, 16'h0, 2'd0, 1'b1);
    cycle(1'b0, 16'h0, 2'd0, 1'b1);
    cycle(1'b0, 16'h0, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
